// File: rtl/reg_hazard_scoreboard.sv
// reg_hazard_scoreboard
//   Tracks in-flight GPR writes between the Read stage and writeback and
//   produces the canRead qualifier consumed by Read.
//   Each register has a saturating in-flight counter:
//     - It increments when an instruction issues with that register as dest/special.
//     - It decrements on writeback.
//   A sticky error flag records writeback underflow and forced overflow.
//
// Ports
//   clk, reset                      rising-edge clock, synchronous active-low reset
//   sourceReg1In/ValidIn            source operand 1 of the decoded instruction
//   sourceReg2In/ValidIn            source operand 2 of the decoded instruction
//   destRegIn/ValidIn               destination of the decoded instruction
//   destRegisterSpecialIn/ValidIn   second destination (e.g. RDX of IMUL)
//   isReadSuccessfulIn              Read stage accepted the instruction this cycle
//   stallIn, wbStallIn              stalls that also gate Read
//   wbRegIn/ValidIn                 register written back this cycle
//   wbRegSpecialIn/ValidIn          second register written back this cycle
//   flushIn                         discard all pending-writer state
//   canReadOut                      no hazard on the current decoded instruction
//   pendingMaskOut                  bit r set while register r has a pending writer
//   underflowErrOut                 sticky writeback-underflow / overflow error
module reg_hazard_scoreboard #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          sourceReg1In,
    input  logic                sourceReg1ValidIn,
    input  logic [3:0]          sourceReg2In,
    input  logic                sourceReg2ValidIn,
    input  logic [3:0]          destRegIn,
    input  logic                destRegValidIn,
    input  logic [3:0]          destRegisterSpecialIn,
    input  logic                destRegisterSpecialValidIn,
    input  logic                isReadSuccessfulIn,
    input  logic                stallIn,
    input  logic                wbStallIn,
    input  logic [3:0]          wbRegIn,
    input  logic                wbRegValidIn,
    input  logic [3:0]          wbRegSpecialIn,
    input  logic                wbRegSpecialValidIn,
    input  logic                flushIn,
    output logic                canReadOut,
    output logic [NUM_REGS-1:0] pendingMaskOut,
    output logic                underflowErrOut
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] counter_q [NUM_REGS];
    logic [CNT_W-1:0] counter_d [NUM_REGS];
    logic             underflow_err_q;
    logic             underflow_err_d;

    // Codes at or above NUM_REGS never match any tracked register.
    function automatic logic hit(input logic valid, input logic [3:0] code,
                                 input int unsigned r);
        return valid && (code == 4'(r));
    endfunction

    always_comb begin
        logic issue;
        logic inc;
        logic dec;
        logic hazard;

        issue           = isReadSuccessfulIn && !stallIn && !wbStallIn;
        inc             = 1'b0;
        dec             = 1'b0;
        hazard          = 1'b0;
        underflow_err_d = underflow_err_q;
        pendingMaskOut  = '0;

        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            // OR of the two hit terms makes dest==special (or wb==wbSpecial)
            // a single event on that register.
            inc = issue && (hit(destRegValidIn, destRegIn, r) ||
                            hit(destRegisterSpecialValidIn, destRegisterSpecialIn, r));
            dec = hit(wbRegValidIn, wbRegIn, r) ||
                  hit(wbRegSpecialValidIn, wbRegSpecialIn, r);

            pendingMaskOut[r] = (counter_q[r] != '0);

            // Hazard looks only at registered counts: a same-cycle writeback
            // does not release the consumer until the following cycle.
            if ((counter_q[r] != '0) &&
                (hit(sourceReg1ValidIn, sourceReg1In, r) ||
                 hit(sourceReg2ValidIn, sourceReg2In, r) ||
                 hit(destRegValidIn, destRegIn, r) ||
                 hit(destRegisterSpecialValidIn, destRegisterSpecialIn, r)))
                hazard = 1'b1;
            if ((counter_q[r] == CNT_MAX) &&
                (hit(destRegValidIn, destRegIn, r) ||
                 hit(destRegisterSpecialValidIn, destRegisterSpecialIn, r)))
                hazard = 1'b1;

            counter_d[r] = counter_q[r];
            if (flushIn) begin
                counter_d[r] = '0;
            end else if (inc && !dec) begin
                if (counter_q[r] == CNT_MAX) underflow_err_d = 1'b1;
                else                         counter_d[r] = counter_q[r] + CNT_W'(1);
            end else if (dec && !inc) begin
                if (counter_q[r] == '0) underflow_err_d = 1'b1;
                else                    counter_d[r] = counter_q[r] - CNT_W'(1);
            end
        end

        canReadOut = !hazard;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) counter_q[r] <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            counter_q       <= counter_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign underflowErrOut = underflow_err_q;

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// tb_reg_hazard_scoreboard
//   Directed bench for reg_hazard_scoreboard. Each cycle pushes the reference
//   model's expected outputs to a queue and pops them against the DUT, and
//   scenario points additionally compare against hand-derived constants.
module tb_reg_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  s1, s2, d, sp, wb, wbs;
    logic        s1v, s2v, dv, spv, rd, stall, wbstall, wbv, wbsv, flush;
    logic        can_read;
    logic [15:0] mask;
    logic        err;

    typedef struct {
        logic        can_read;
        logic [15:0] mask;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   mcnt[16];
    logic merr;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    reg_hazard_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .sourceReg1In               (s1),
        .sourceReg1ValidIn          (s1v),
        .sourceReg2In               (s2),
        .sourceReg2ValidIn          (s2v),
        .destRegIn                  (d),
        .destRegValidIn             (dv),
        .destRegisterSpecialIn      (sp),
        .destRegisterSpecialValidIn (spv),
        .isReadSuccessfulIn         (rd),
        .stallIn                    (stall),
        .wbStallIn                  (wbstall),
        .wbRegIn                    (wb),
        .wbRegValidIn               (wbv),
        .wbRegSpecialIn             (wbs),
        .wbRegSpecialValidIn        (wbsv),
        .flushIn                    (flush),
        .canReadOut                 (can_read),
        .pendingMaskOut             (mask),
        .underflowErrOut            (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        {s1, s2, d, sp, wb, wbs} = '0;
        {s1v, s2v, dv, spv, rd, stall, wbstall, wbv, wbsv, flush} = '0;
    endtask

    function automatic logic model_can_read();
        logic h = 1'b0;
        if (s1v && mcnt[s1] != 0) h = 1'b1;
        if (s2v && mcnt[s2] != 0) h = 1'b1;
        if (dv  && (mcnt[d]  != 0 || mcnt[d]  == 3)) h = 1'b1;
        if (spv && (mcnt[sp] != 0 || mcnt[sp] == 3)) h = 1'b1;
        return !h;
    endfunction

    function automatic logic [15:0] model_mask();
        logic [15:0] m = '0;
        for (int i = 0; i < 16; i++) m[i] = (mcnt[i] != 0);
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mcnt[i] = 0;
        merr = 1'b0;
    endtask

    task automatic model_update();
        logic issue, inc, dec;
        if (!reset) begin
            model_clear();
        end else if (flush) begin
            for (int i = 0; i < 16; i++) mcnt[i] = 0;
        end else begin
            issue = rd && !stall && !wbstall;
            for (int i = 0; i < 16; i++) begin
                inc = issue && ((dv && d == i) || (spv && sp == i));
                dec = (wbv && wb == i) || (wbsv && wbs == i);
                if (inc && !dec) begin
                    if (mcnt[i] == 3) merr = 1'b1;
                    else              mcnt[i]++;
                end else if (dec && !inc) begin
                    if (mcnt[i] == 0) merr = 1'b1;
                    else              mcnt[i]--;
                end
            end
        end
    endtask

    // Inputs are already driven (just after a negedge): compare the model
    // against the combinational outputs, then clock once.
    task automatic cycle(input string tag);
        exp_t e, g;
        #1;
        e.can_read = model_can_read();
        e.mask     = model_mask();
        e.err      = merr;
        sb.push_back(e);
        g = sb.pop_front();
        check({tag, ".can_read"}, 32'(can_read), 32'(g.can_read));
        check({tag, ".mask"},     32'(mask),     32'(g.mask));
        check({tag, ".err"},      32'(err),      32'(g.err));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        clr();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        reset = 1'b1;

        // Reset state
        #1;
        check("rst_can_read", 32'(can_read), 32'd1);
        check("rst_mask",     32'(mask),     32'h0);
        check("rst_err",      32'(err),      32'd0);
        cycle("idle");

        // RAW on r3
        clr(); dv = 1; d = 3; rd = 1; cycle("raw_issue");
        clr(); s1v = 1; s1 = 3; #1;
        check("raw_block", 32'(can_read), 32'd0);
        check("raw_mask",  32'(mask),     32'h0008);
        cycle("raw_hold");
        clr(); s1v = 1; s1 = 3; wbv = 1; wb = 3; #1;
        check("raw_wb_same_cycle", 32'(can_read), 32'd0);
        cycle("raw_wb");
        clr(); s1v = 1; s1 = 3; #1;
        check("raw_release", 32'(can_read), 32'd1);
        check("raw_mask_clear", 32'(mask), 32'h0);
        cycle("raw_done");

        // Special destination r0 + r2
        clr(); dv = 1; d = 0; spv = 1; sp = 2; rd = 1; cycle("spec_issue");
        clr(); s2v = 1; s2 = 2; #1;
        check("spec_mask",  32'(mask),     32'h0005);
        check("spec_block", 32'(can_read), 32'd0);
        cycle("spec_hold");
        clr(); s2v = 1; s2 = 2; wbv = 1; wb = 0; wbsv = 1; wbs = 2; #1;
        check("spec_wb_same_cycle", 32'(can_read), 32'd0);
        cycle("spec_wb");
        clr(); s2v = 1; s2 = 2; #1;
        check("spec_release", 32'(can_read), 32'd1);
        check("spec_mask_clear", 32'(mask), 32'h0);
        cycle("spec_done");

        // Simultaneous issue + writeback on r5
        clr(); dv = 1; d = 5; rd = 1; cycle("sim_issue");
        clr(); dv = 1; d = 5; rd = 1; wbv = 1; wb = 5; cycle("sim_both");
        clr(); #1;
        check("sim_mask", 32'(mask), 32'h0020);
        cycle("sim_idle");
        clr(); wbv = 1; wb = 5; cycle("sim_retire");
        clr(); #1;
        check("sim_mask_clear", 32'(mask), 32'h0);

        // dest == special and wb == wbSpecial each count once
        clr(); dv = 1; d = 6; spv = 1; sp = 6; rd = 1; cycle("dual_issue");
        clr(); dv = 1; d = 6; rd = 1; cycle("dual_issue2");
        clr(); wbv = 1; wb = 6; wbsv = 1; wbs = 6; cycle("dual_wb");
        clr(); #1;
        check("dual_mask", 32'(mask), 32'h0040);
        check("dual_err",  32'(err),  32'd0);
        clr(); wbv = 1; wb = 6; cycle("dual_retire");
        clr(); #1;
        check("dual_mask_clear", 32'(mask), 32'h0);
        check("dual_err_clear",  32'(err),  32'd0);

        // Saturation on r7, then stalled issues
        for (int i = 0; i < 3; i++) begin
            clr(); dv = 1; d = 7; rd = 1; cycle("sat_issue");
        end
        clr(); dv = 1; d = 7; #1;
        check("sat_block", 32'(can_read), 32'd0);
        check("sat_mask",  32'(mask),     32'h0080);
        clr(); dv = 1; d = 4; rd = 1; stall = 1;   cycle("stall_issue");
        clr(); dv = 1; d = 4; rd = 1; wbstall = 1; cycle("wbstall_issue");
        clr(); #1;
        check("stall_mask", 32'(mask), 32'h0080);
        check("stall_err",  32'(err),  32'd0);

        // Flush overrides same-cycle issue and writeback
        clr(); dv = 1; d = 3; rd = 1; cycle("flush_prep");
        clr(); #1;
        check("flush_pre_mask", 32'(mask), 32'h0088);
        clr(); flush = 1; dv = 1; d = 1; rd = 1; wbv = 1; wb = 7; cycle("flush");
        clr(); #1;
        check("flush_mask", 32'(mask), 32'h0);
        check("flush_err",  32'(err),  32'd0);

        // Underflow on r9, sticky
        clr(); wbv = 1; wb = 9; cycle("uf_wb");
        clr(); #1;
        check("uf_err",  32'(err),  32'd1);
        check("uf_mask", 32'(mask), 32'h0);
        cycle("uf_idle");
        clr(); #1;
        check("uf_sticky", 32'(err), 32'd1);

        // Reset mid-operation
        clr(); dv = 1; d = 2; rd = 1; cycle("rst_prep");
        clr(); reset = 0; dv = 1; d = 1; rd = 1; wbv = 1; wb = 2; cycle("rst_mid");
        clr(); reset = 1; #1;
        check("rst_mid_mask", 32'(mask), 32'h0);
        check("rst_mid_err",  32'(err),  32'd0);

        // Forced overflow holds at max and raises the error
        for (int i = 0; i < 4; i++) begin
            clr(); dv = 1; d = 7; rd = 1; cycle("of_issue");
        end
        clr(); #1;
        check("of_err",  32'(err),  32'd1);
        check("of_mask", 32'(mask), 32'h0080);
        clr(); wbv = 1; wb = 7; cycle("of_retire");
        clr(); #1;
        check("of_held", 32'(mask), 32'h0080);
        cycle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
